pokey_poly_ctrl: RTL and testbench

- Sequencer and owner of the POKEY polynomial noise sources.
- Derives the poly tick from the machine-clock enable and drives the enable/init pair of the external 4-bit poly counter.
- Hosts the 5-bit and 9/17-bit poly counters internally and runs the SKCTL init/flush state machine.
- Captures the RANDOM register on CPU read; sits between the POKEY register file and the audio channel noise mux.

---
 rtl/pokey_poly_ctrl_if.sv | 23 ++
 rtl/pokey_poly_ctrl.sv | 131 +++++++++++++
 tb/tb_pokey_poly_ctrl.sv | 364 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pokey_poly_ctrl_if.sv
// Register-file / noise-mux side of the POKEY poly sequencer.
// The master drives SKCTL/AUDCTL/RANDOM-read controls; the slave returns the poly outputs.
interface pokey_poly_ctrl_if;
    logic       skctl_init;
    logic       poly9_sel;
    logic       rnd_rd;
    logic       poly4_enable;
    logic       poly4_init;
    logic       poly5_bit;
    logic       poly17_bit;
    logic [7:0] random_q;
    logic [1:0] ctrl_state;

    modport master (
        output skctl_init, poly9_sel, rnd_rd,
        input  poly4_enable, poly4_init, poly5_bit, poly17_bit, random_q, ctrl_state
    );

    modport slave (
        input  skctl_init, poly9_sel, rnd_rd,
        output poly4_enable, poly4_init, poly5_bit, poly17_bit, random_q, ctrl_state
    );
endinterface

// File: rtl/pokey_poly_ctrl.sv
// POKEY poly tick divider, 5-bit and 9/17-bit noise polys, SKCTL init/flush FSM, RANDOM capture.
// Optional macro POKEY_POLY_FREEZE_EN adds a freeze input that stalls the tick.
module pokey_poly_ctrl #(
    parameter int unsigned CE_DIV      = 1,
    parameter int unsigned FLUSH_TICKS = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic ce,
`ifdef POKEY_POLY_FREEZE_EN
    input  logic freeze,
`endif
    pokey_poly_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_INIT  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  div_cnt_q, div_cnt_d;
    logic [3:0]  flush_cnt_q, flush_cnt_d;
    logic [4:0]  poly5_q, poly5_d;
    logic [16:0] poly17_q, poly17_d;
    logic [7:0]  random_q_q, random_q_d;

    logic frz;
    logic tick;
    logic init_act;
    logic fb5, fb9, fb17;

`ifdef POKEY_POLY_FREEZE_EN
    assign frz = freeze;
`else
    assign frz = 1'b0;
`endif

    assign tick     = ce & ~frz & (div_cnt_q == 4'(CE_DIV - 1));
    assign init_act = (state_q != ST_RUN);

    // Init forces zero feedback so the polys flush to all-zero while ticks keep running.
    assign fb5  = ~(poly5_q[2]  ^ poly5_q[0])  & ~init_act;
    assign fb17 = ~(poly17_q[5] ^ poly17_q[0]) & ~init_act;
    assign fb9  = ~(poly17_q[4] ^ poly17_q[0]) & ~init_act;

    always_comb begin
        div_cnt_d  = div_cnt_q;
        poly5_d    = poly5_q;
        poly17_d   = poly17_q;
        random_q_d = random_q_q;

        if (ce && !frz) begin
            div_cnt_d = tick ? '0 : div_cnt_q + 4'd1;
        end

        if (tick) begin
            poly5_d = {fb5, poly5_q[4:1]};
            if (bus.poly9_sel) begin
                poly17_d = {fb9, poly17_q[16:10], fb9, poly17_q[8:1]};
            end else begin
                poly17_d = {fb17, poly17_q[16:1]};
            end
        end

        if (bus.rnd_rd) begin
            random_q_d = poly17_q[16:9];
        end
    end

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        case (state_q)
            ST_RUN: begin
                if (bus.skctl_init) state_d = ST_INIT;
            end
            ST_INIT: begin
                if (!bus.skctl_init) begin
                    state_d     = ST_FLUSH;
                    flush_cnt_d = '0;
                end
            end
            ST_FLUSH: begin
                if (bus.skctl_init) begin
                    state_d = ST_INIT;
                end else if (tick) begin
                    if (flush_cnt_q == 4'(FLUSH_TICKS - 1)) begin
                        state_d = ST_RUN;
                    end else begin
                        flush_cnt_d = flush_cnt_q + 4'd1;
                    end
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_RUN;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt_q  <= '0;
            poly5_q    <= '0;
            poly17_q   <= '0;
            random_q_q <= '0;
        end else begin
            div_cnt_q  <= div_cnt_d;
            poly5_q    <= poly5_d;
            poly17_q   <= poly17_d;
            random_q_q <= random_q_d;
        end
    end

    assign bus.poly4_enable = tick;
    assign bus.poly4_init   = init_act;
    assign bus.poly5_bit    = poly5_q[0];
    assign bus.poly17_bit   = poly17_q[0];
    assign bus.random_q     = random_q_q;
    assign bus.ctrl_state   = state_q;

endmodule

// File: tb/tb_pokey_poly_ctrl.sv
// Self-checking bench for pokey_poly_ctrl: two instances (CE_DIV=1 and CE_DIV=3)
// compared cycle by cycle against a behavioural model of the poly/flush rules.
module tb_pokey_poly_ctrl;

    localparam int FT = 4;

    logic clk = 1'b0;
    logic reset;
    logic ce, skctl, sel9, rd, frz;

    int checks   = 0;
    int failures = 0;
    bit use3     = 1'b0;
    int m_cediv  = 1;

    int          m_div, m_st, m_fc;
    logic [4:0]  m_p5;
    logic [16:0] m_p17;
    logic [7:0]  m_rnd;

    pokey_poly_ctrl_if bus1 ();
    pokey_poly_ctrl_if bus3 ();

    assign bus1.skctl_init = skctl;
    assign bus1.poly9_sel  = sel9;
    assign bus1.rnd_rd     = rd;
    assign bus3.skctl_init = skctl;
    assign bus3.poly9_sel  = sel9;
    assign bus3.rnd_rd     = rd;

    pokey_poly_ctrl #(.CE_DIV(1), .FLUSH_TICKS(FT)) dut1 (
        .clk(clk), .reset(reset), .ce(ce),
`ifdef POKEY_POLY_FREEZE_EN
        .freeze(frz),
`endif
        .bus(bus1)
    );

    pokey_poly_ctrl #(.CE_DIV(3), .FLUSH_TICKS(FT)) dut3 (
        .clk(clk), .reset(reset), .ce(ce),
`ifdef POKEY_POLY_FREEZE_EN
        .freeze(frz),
`endif
        .bus(bus3)
    );

    always #5 clk = ~clk;

    logic       o_en, o_init, o_p5, o_p17;
    logic [7:0] o_rnd;
    logic [1:0] o_st;

    always_comb begin
        if (use3) begin
            o_en = bus3.poly4_enable; o_init = bus3.poly4_init; o_p5 = bus3.poly5_bit;
            o_p17 = bus3.poly17_bit; o_rnd = bus3.random_q; o_st = bus3.ctrl_state;
        end else begin
            o_en = bus1.poly4_enable; o_init = bus1.poly4_init; o_p5 = bus1.poly5_bit;
            o_p17 = bus1.poly17_bit; o_rnd = bus1.random_q; o_st = bus1.ctrl_state;
        end
    end

    function automatic bit m_tick();
        return ce && !frz && (m_div == m_cediv - 1);
    endfunction

    task automatic model_reset();
        m_div = 0; m_st = 0; m_fc = 0; m_p5 = '0; m_p17 = '0; m_rnd = '0;
    endtask

    // Behavioural update for one clock edge, from the values before the edge.
    task automatic model_edge();
        bit   t;
        bit   init;
        logic fb;
        t    = m_tick();
        init = (m_st != 0);
        if (rd) m_rnd = 8'((m_p17 >> 9) & 17'hFF);
        if (t) begin
            fb   = init ? 1'b0 : ~(m_p5[2] ^ m_p5[0]);
            m_p5 = (m_p5 >> 1) | (5'(fb) << 4);
            if (sel9) begin
                fb    = init ? 1'b0 : ~(m_p17[4] ^ m_p17[0]);
                m_p17 = m_p17 >> 1;
                m_p17[16] = fb;
                m_p17[8]  = fb;
            end else begin
                fb    = init ? 1'b0 : ~(m_p17[5] ^ m_p17[0]);
                m_p17 = (m_p17 >> 1) | (17'(fb) << 16);
            end
        end
        case (m_st)
            0: if (skctl) m_st = 1;
            1: if (!skctl) begin m_st = 2; m_fc = 0; end
            default: begin
                if (skctl) m_st = 1;
                else if (t) begin
                    m_fc++;
                    if (m_fc == FT) m_st = 0;
                end
            end
        endcase
        if (ce && !frz) m_div = t ? 0 : m_div + 1;
    endtask

    task automatic step();
        #2;
        checks++;
        if (o_en !== m_tick()) begin
            failures++; $display("FAIL poly4_enable t=%0t got=%b exp=%b", $time, o_en, m_tick());
        end
        @(posedge clk); #1;
        model_edge();
        checks++;
        if (o_st !== m_st[1:0]) begin
            failures++; $display("FAIL ctrl_state t=%0t got=%0d exp=%0d", $time, o_st, m_st);
        end
        checks++;
        if (o_init !== (m_st != 0)) begin
            failures++; $display("FAIL poly4_init t=%0t got=%b exp=%b", $time, o_init, m_st != 0);
        end
        checks++;
        if (o_p5 !== m_p5[0]) begin
            failures++; $display("FAIL poly5_bit t=%0t got=%b exp=%b", $time, o_p5, m_p5[0]);
        end
        checks++;
        if (o_p17 !== m_p17[0]) begin
            failures++; $display("FAIL poly17_bit t=%0t got=%b exp=%b", $time, o_p17, m_p17[0]);
        end
        checks++;
        if (o_rnd !== m_rnd) begin
            failures++; $display("FAIL random_q t=%0t got=%h exp=%h", $time, o_rnd, m_rnd);
        end
    endtask

    task automatic do_reset();
        ce = 1'b0; skctl = 1'b0; sel9 = 1'b0; rd = 1'b0; frz = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        use3 = 1'b0;
        do_reset();
        #1;
        checks++;
        if (o_st !== 2'd0 || o_init !== 1'b0 || o_en !== 1'b0) begin
            failures++; $display("FAIL reset_ctrl got st=%0d init=%b en=%b exp 0/0/0", o_st, o_init, o_en);
        end
        checks++;
        if (o_rnd !== 8'h00 || o_p5 !== 1'b0 || o_p17 !== 1'b0) begin
            failures++; $display("FAIL reset_poly got rnd=%h p5=%b p17=%b exp 00/0/0", o_rnd, o_p5, o_p17);
        end
    endtask

    task automatic test_poly5();
        bit exp_b [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        use3 = 1'b0;
        do_reset();
        ce = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (o_en !== 1'b1) begin
                failures++; $display("FAIL poly5_tick_every_cycle i=%0d got=%b exp=1", i, o_en);
            end
            step();
            checks++;
            if (o_p5 !== exp_b[i]) begin
                failures++; $display("FAIL poly5_seq tick=%0d got=%b exp=%b", i + 1, o_p5, exp_b[i]);
            end
        end
    endtask

    task automatic test_random_capture();
        use3 = 1'b0;
        do_reset();
        ce = 1'b1;
        for (int i = 0; i < 4; i++) step();
        rd = 1'b1; step(); rd = 1'b0;
        checks++;
        if (o_rnd !== 8'hF0) begin
            failures++; $display("FAIL random_4ticks got=%h exp=f0", o_rnd);
        end
        for (int i = 0; i < 3; i++) step();
        rd = 1'b1; step(); rd = 1'b0;
        checks++;
        if (o_rnd !== 8'hFF) begin
            failures++; $display("FAIL random_8ticks got=%h exp=ff", o_rnd);
        end
    endtask

    task automatic test_ce_div3();
        int en_cnt = 0;
        int bad    = 0;
        use3 = 1'b1; m_cediv = 3;
        do_reset();
        for (int i = 0; i < 30; i++) begin
            ce = (i % 2 == 0);
            #1;
            if (o_en) en_cnt++;
            if (o_en && !ce) bad++;
            step();
        end
        checks++;
        if (en_cnt !== 5) begin
            failures++; $display("FAIL div3_pulse_count got=%0d exp=5", en_cnt);
        end
        checks++;
        if (bad !== 0) begin
            failures++; $display("FAIL div3_pulse_without_ce got=%0d exp=0", bad);
        end
        ce = 1'b0;
        use3 = 1'b0; m_cediv = 1;
    endtask

    task automatic count_flush(input string name);
        int n = 0;
        while (o_st != 2'd0 && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (n !== FT) begin
            failures++; $display("FAIL %s flush_len got=%0d exp=%0d", name, n, FT);
        end
    endtask

    task automatic test_init_flush();
        use3 = 1'b0;
        do_reset();
        ce = 1'b1;
        for (int i = 0; i < 20; i++) step();
        skctl = 1'b1; step(); step();
        checks++;
        if (o_st !== 2'd1 || o_init !== 1'b1) begin
            failures++; $display("FAIL init_entry got st=%0d init=%b exp 1/1", o_st, o_init);
        end
        skctl = 1'b0; step();
        checks++;
        if (o_st !== 2'd2) begin
            failures++; $display("FAIL flush_entry got=%0d exp=2", o_st);
        end
        count_flush("flush");
        rd = 1'b1; step(); rd = 1'b0;
        checks++;
        if (o_rnd[7:3] !== 5'd0) begin
            failures++; $display("FAIL poly17_top_zero got=%h exp=00", o_rnd[7:3]);
        end
    endtask

    task automatic test_flush_restart();
        use3 = 1'b0;
        ce = 1'b1;
        skctl = 1'b1; step();
        skctl = 1'b0; step();
        step(); step();
        skctl = 1'b1; step();
        checks++;
        if (o_st !== 2'd1) begin
            failures++; $display("FAIL flush_reinit got=%0d exp=1", o_st);
        end
        skctl = 1'b0; step();
        count_flush("restart");
    endtask

    task automatic test_reset_mid_flush();
        use3 = 1'b0;
        ce = 1'b1;
        for (int i = 0; i < 9; i++) step();
        skctl = 1'b1; step();
        skctl = 1'b0; step(); step();
        #2 reset = 1'b1;
        #1;
        checks++;
        if (o_st !== 2'd0 || o_init !== 1'b0 || o_rnd !== 8'h00 || o_p5 !== 1'b0 || o_p17 !== 1'b0) begin
            failures++; $display("FAIL reset_mid_flush got st=%0d init=%b rnd=%h exp 0/0/00", o_st, o_init, o_rnd);
        end
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 6; i++) step();
    endtask

    task automatic test_back_to_back();
        use3 = 1'b0;
        do_reset();
        ce = 1'b1;
        rd = 1'b1;
        for (int i = 0; i < 40; i++) begin
            sel9 = (i >= 20);
            step();
        end
        rd = 1'b0;
    endtask

    task automatic test_random_stim(input bit which);
        use3 = which; m_cediv = which ? 3 : 1;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            ce = ($urandom_range(0, 3) != 0);
            rd = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 15) == 0) sel9 = ~sel9;
            if ($urandom_range(0, 39) == 0) skctl = ~skctl;
            step();
        end
        ce = 1'b0; rd = 1'b0; skctl = 1'b0;
        use3 = 1'b0; m_cediv = 1;
    endtask

`ifdef POKEY_POLY_FREEZE_EN
    task automatic test_freeze();
        logic [7:0] snap;
        use3 = 1'b0;
        do_reset();
        ce = 1'b1;
        for (int i = 0; i < 7; i++) step();
        frz = 1'b1;
        rd = 1'b1; step(); rd = 1'b0;
        snap = m_rnd;
        for (int i = 0; i < 10; i++) step();
        rd = 1'b1; step(); rd = 1'b0;
        checks++;
        if (o_rnd !== snap) begin
            failures++; $display("FAIL freeze_hold got=%h exp=%h", o_rnd, snap);
        end
        skctl = 1'b1; step();
        checks++;
        if (o_st !== 2'd1) begin
            failures++; $display("FAIL freeze_init_honoured got=%0d exp=1", o_st);
        end
        skctl = 1'b0; step();
        frz = 1'b0;
        for (int i = 0; i < 12; i++) step();
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_poly5();
        test_random_capture();
        test_ce_div3();
        test_init_flush();
        test_flush_restart();
        test_reset_mid_flush();
        test_back_to_back();
        test_random_stim(1'b0);
        test_random_stim(1'b1);
`ifdef POKEY_POLY_FREEZE_EN
        test_freeze();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
